// File: rtl/bmem_arbiter.sv
// bmem_arbiter: shares one burst memory port (BEATS x BEAT_W per line) between
// the read-only instruction cache and the read/write data cache. Exactly one
// whole-line transaction is in flight; write lines leave as beats and read
// beats are collected into a line buffer before the requester is answered.
// Build option: define BMEM_ARB_RR_EN for round-robin arbitration on
// contention; without it the dcache always wins.
module bmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4,
  parameter int LINE_W = BEAT_W * BEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_resp,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD_CMD, S_RD_WAIT, S_WR, S_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_gnt_d;     // 1 = current transaction belongs to dcache
  logic              r_we;        // 1 = current transaction is a line write
  logic [ADDR_W-1:0] r_addr;      // stored already line-aligned
  logic [BEAT_W-1:0] r_beats [BEATS];
  logic [LINE_W-1:0] r_ic_rdata, r_dc_rdata, w_line;
  logic              w_pick_d, w_start, w_rd_acc, w_wr_acc, w_last;
  logic [ADDR_W-1:0] w_ic_aligned, w_dc_aligned;
  logic              w_unused_addr_bits;

  // Byte offset within a line never reaches the memory port.
  assign w_ic_aligned       = {ic_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_dc_aligned       = {dc_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_unused_addr_bits = ^{ic_addr[OFF_W-1:0], dc_addr[OFF_W-1:0]};

`ifdef BMEM_ARB_RR_EN
  logic r_last_d;  // 1 = previous completed grant went to dcache
  assign w_pick_d = dc_req & (~ic_req | ~r_last_d);
`else
  assign w_pick_d = dc_req;
`endif

  assign w_start  = (r_state == S_IDLE) & (dc_req | ic_req);
  // Only beats tagged with our own line address count; strays are dropped.
  assign w_rd_acc = (r_state == S_RD_WAIT) & bmem_rvalid & (bmem_raddr == r_addr);
  assign w_wr_acc = (r_state == S_WR) & bmem_ready;
  assign w_last   = (r_cnt == LAST_BEAT);

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_line
      assign w_line[gi*BEAT_W +: BEAT_W] = r_beats[gi];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and output decode; rdata shows the fresh line during DONE.
  always_comb begin
    w_state_next = r_state;
    bmem_read    = 1'b0;
    bmem_write   = 1'b0;
    bmem_addr    = '0;
    bmem_wdata   = '0;
    ic_resp      = 1'b0;
    dc_resp      = 1'b0;
    ic_rdata     = r_ic_rdata;
    dc_rdata     = r_dc_rdata;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_state_next = (w_pick_d & dc_we) ? S_WR : S_RD_CMD;
      end
      S_RD_CMD: begin
        bmem_read = 1'b1;
        bmem_addr = r_addr;
        if (bmem_ready) w_state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (w_rd_acc & w_last) w_state_next = S_DONE;
      end
      S_WR: begin
        bmem_write = 1'b1;
        bmem_addr  = r_addr;
        bmem_wdata = r_beats[r_cnt];
        if (w_wr_acc & w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        ic_resp = ~r_gnt_d;
        dc_resp = r_gnt_d;
        if (!r_we) begin
          if (r_gnt_d) dc_rdata = w_line;
          else         ic_rdata = w_line;
        end
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Grant capture, beat counter and line buffer (write load / read assembly).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_gnt_d <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      for (int i = 0; i < BEATS; i++) r_beats[i] <= '0;
    end else begin
      if (w_start) begin
        r_cnt   <= '0;
        r_gnt_d <= w_pick_d;
        r_we    <= w_pick_d & dc_we;
        r_addr  <= w_pick_d ? w_dc_aligned : w_ic_aligned;
        if (w_pick_d & dc_we) begin
          for (int i = 0; i < BEATS; i++) r_beats[i] <= dc_wdata[i*BEAT_W +: BEAT_W];
        end
      end
      if ((r_state == S_RD_CMD) & bmem_ready) r_cnt <= '0;
      if (w_rd_acc) begin
        r_beats[r_cnt] <= bmem_rdata;
        r_cnt          <= r_cnt + CNT_W'(1);
      end
      if (w_wr_acc) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Per-requester read lines hold until that requester's next read finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ic_rdata <= '0;
      r_dc_rdata <= '0;
    end else if ((r_state == S_DONE) && !r_we) begin
      if (r_gnt_d) r_dc_rdata <= w_line;
      else         r_ic_rdata <= w_line;
    end
  end

`ifdef BMEM_ARB_RR_EN
  // Remember who was served last so contention alternates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_last_d <= 1'b0;
    else if (r_state == S_DONE) r_last_d <= r_gnt_d;
  end
`endif

endmodule

// File: tb/tb_bmem_arbiter.sv
`timescale 1ns/1ps
// tb_bmem_arbiter: drives cache requests and plays the burst memory, checking
// the arbiter against a line-level model (who wins, which beats, which lines).
module tb_bmem_arbiter;
  localparam int AW = 32, BW = 64, NB = 4, LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req, ic_resp, dc_req, dc_we, dc_resp;
  logic [AW-1:0] ic_addr, dc_addr, bmem_addr, bmem_raddr;
  logic [LW-1:0] ic_rdata, dc_wdata, dc_rdata;
  logic          bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [BW-1:0] bmem_wdata, bmem_rdata;

  bmem_arbiter #(.ADDR_W(AW), .BEAT_W(BW), .BEATS(NB)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_resp(ic_resp),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_resp(dc_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

`ifdef BMEM_ARB_RR_EN
  localparam bit SECOND_D = 1'b0;
`else
  localparam bit SECOND_D = 1'b1;
`endif

  int total = 0, bad = 0, ntx = 0;

  // model state: last line each cache received, last served requester
  logic [LW-1:0] exp_ic_line, exp_dc_line;
  bit            mdl_last_d;
  logic [31:0]   mix;

  // observations of the latest transaction
  int            lat, n_rd_cyc, n_wr_cyc, n_addr_bad, n_d1_cyc;
  bit            got_ic, got_dc;
  logic [LW-1:0] obs_ic, obs_dc;
  logic [BW-1:0] wr_acc[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // memory content of beat k of any line: byte (k+1)*0x11 repeated, xor mix
  function automatic logic [BW-1:0] beat_val(input int k);
    logic [7:0] b;
    b = 8'((k + 1) * 17);
    return {8{b}} ^ {mix, mix};
  endfunction

  function automatic logic [LW-1:0] exp_line();
    logic [LW-1:0] l;
    for (int k = 0; k < NB; k++) l[k*BW +: BW] = beat_val(k);
    return l;
  endfunction

  // One arbitrated transaction, entered at a negedge with the DUT idle.
  // stall: 0 ready high, 1 random ready, 2 ready low twice on write beat 1.
  // noisy: random read-beat gaps plus stray beats. abort_at>0: reset after
  // that many beats returned. keep: leave both requests raised after resp.
  task automatic run_txn(input bit ic_on, input bit dc_on, input bit we,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [LW-1:0] wd, input int stall,
                         input bit noisy, input int abort_at, input bit keep);
    logic [BW-1:0] rq[$];
    logic [31:0]   exp_addr, cmd_addr;
    bit            win_d, done, rd_active;
    int            given, hold, cyc;
`ifdef BMEM_ARB_RR_EN
    win_d = dc_on && (!ic_on || !mdl_last_d);
`else
    win_d = dc_on;
`endif
    exp_addr = (win_d ? da : ia) & ~32'h1f;
    wr_acc.delete();
    n_rd_cyc = 0; n_wr_cyc = 0; n_addr_bad = 0; n_d1_cyc = 0;
    given = 0; hold = (stall == 2) ? 2 : 0; done = 0; cyc = 0; rd_active = 0;
    cmd_addr = '0;
    ic_req = ic_on; ic_addr = ia; dc_req = dc_on; dc_we = we; dc_addr = da; dc_wdata = wd;
    while (!done) begin
      if (ic_resp || dc_resp) begin
        done = 1; lat = cyc; got_ic = ic_resp; got_dc = dc_resp;
        obs_ic = ic_rdata; obs_dc = dc_rdata;
        if (!keep) begin ic_req = 0; dc_req = 0; end
        bmem_rvalid = 0; bmem_ready = 0;
      end else begin
        if (abort_at > 0 && given == abort_at) begin
          rst = 1; ic_req = 0; dc_req = 0; bmem_rvalid = 0; bmem_ready = 0;
          #1;
          check("rst_bus", 256'({bmem_read, bmem_write, bmem_addr, bmem_wdata}), 256'(0));
          check("rst_resp", 256'({ic_resp, dc_resp}), 256'(0));
          check("rst_ic_rdata", ic_rdata, 256'(0));
          check("rst_dc_rdata", dc_rdata, 256'(0));
          @(negedge clk);
          rst = 0;
          while (rq.size() > 0) begin
            bmem_ready = 1; bmem_rvalid = 1; bmem_raddr = cmd_addr; bmem_rdata = rq.pop_front();
            @(negedge clk);
            check("late_beat_resp", 256'({ic_resp, dc_resp}), 256'(0));
            check("late_beat_cmd", 256'({bmem_read, bmem_write}), 256'(0));
          end
          bmem_rvalid = 0;
          @(negedge clk);
          check("late_ic_rdata", ic_rdata, 256'(0));
          exp_ic_line = '0; exp_dc_line = '0; mdl_last_d = 0;
          $display("txn %0d: icache read addr=%h aborted by reset", ntx, exp_addr);
          ntx++;
          return;
        end
        // read-beat channel (decided before a command issued this cycle)
        bmem_rvalid = 0; bmem_raddr = $urandom; bmem_rdata = {$urandom, $urandom};
        if (rq.size() > 0 && (!noisy || (cyc % 2 == 0 && $urandom_range(2) != 0))) begin
          bmem_rvalid = 1; bmem_raddr = cmd_addr; bmem_rdata = rq.pop_front(); given++;
        end else if (noisy && (rd_active || $urandom_range(2) == 0)) begin
          bmem_rvalid = 1;
          bmem_raddr  = rd_active ? (cmd_addr ^ 32'h20) : exp_addr;
        end
        if (stall == 0) bmem_ready = 1;
        else if (stall == 1) bmem_ready = ($urandom_range(3) != 0);
        else begin
          bmem_ready = 1;
          if (bmem_write && wr_acc.size() == 1 && hold > 0) begin bmem_ready = 0; hold--; end
        end
        if (bmem_read) begin
          n_rd_cyc++;
          if (bmem_addr !== exp_addr) n_addr_bad++;
          if (bmem_ready) begin
            cmd_addr = bmem_addr; rd_active = 1;
            for (int k = 0; k < NB; k++) rq.push_back(beat_val(k));
          end
        end
        if (bmem_write) begin
          n_wr_cyc++;
          if (bmem_addr !== exp_addr) n_addr_bad++;
          if (bmem_wdata === wd[127:64]) n_d1_cyc++;
          if (bmem_ready) wr_acc.push_back(bmem_wdata);
        end
        cyc++;
        if (cyc > 300) begin
          check("resp_within_budget", 256'(ic_resp | dc_resp), 256'(1));
          ic_req = 0; dc_req = 0; bmem_rvalid = 0;
          return;
        end
        @(negedge clk);
      end
    end
    check("winner_is_dc", 256'(got_dc), 256'(win_d));
    check("single_resp", 256'(got_ic & got_dc), 256'(0));
    check("bus_addr_bad_cycles", 256'(n_addr_bad), 256'(0));
    if (win_d && we) begin
      check("wr_beat_count", 256'(wr_acc.size()), 256'(NB));
      for (int k = 0; k < NB && k < wr_acc.size(); k++)
        check($sformatf("wr_beat%0d", k), 256'(wr_acc[k]), 256'(wd[k*BW +: BW]));
      check("no_read_on_write", 256'(n_rd_cyc), 256'(0));
    end else begin
      if (win_d) exp_dc_line = exp_line();
      else       exp_ic_line = exp_line();
      check("no_write_on_read", 256'(n_wr_cyc), 256'(0));
    end
    check("ic_rdata_at_resp", obs_ic, exp_ic_line);
    check("dc_rdata_at_resp", obs_dc, exp_dc_line);
    mdl_last_d = win_d;
    $display("txn %0d: %s %s addr=%h lat=%0d", ntx, win_d ? "dcache" : "icache",
             (win_d && we) ? "write" : "read", exp_addr, lat);
    ntx++;
    @(negedge clk);
    check("resp_one_cycle", 256'({ic_resp, dc_resp}), 256'(0));
    check("ic_rdata_hold", ic_rdata, exp_ic_line);
  endtask

  logic [LW-1:0] wd;
  logic [31:0]   ra, rb;
  bit            rwe, lose_d;
  int            kind;

  initial begin
    rst = 1; ic_req = 0; dc_req = 0; dc_we = 0; ic_addr = '0; dc_addr = '0; dc_wdata = '0;
    bmem_ready = 0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 0;
    mix = '0; exp_ic_line = '0; exp_dc_line = '0; mdl_last_d = 0;
    repeat (2) @(negedge clk);
    check("reset_bus", 256'({bmem_read, bmem_write, bmem_addr, bmem_wdata}), 256'(0));
    check("reset_resp", 256'({ic_resp, dc_resp}), 256'(0));
    check("reset_rdata", ic_rdata | dc_rdata, 256'(0));
    rst = 0;
    @(negedge clk);

    // icache read: one command cycle, beats start the cycle after accept
    run_txn(1, 0, 0, 32'h0000_1234, 32'h0, '0, 0, 0, 0, 0);
    check("t1_read_cmd_cycles", 256'(n_rd_cyc), 256'(1));
    check("t1_latency", 256'(lat), 256'(6));
    check("t1_line", obs_ic, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    check("t1_no_dc_resp", 256'(got_dc), 256'(0));

    // dcache write, ready held high: IDLE + 4 WR + DONE
    wd = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
          64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
    run_txn(0, 1, 1, 32'h0, 32'h8000_0040, wd, 0, 0, 0, 0);
    check("t2_write_cycles", 256'(n_wr_cyc), 256'(4));
    check("t2_latency", 256'(lat), 256'(5));

    // same write, beat 1 stalled for two cycles
    run_txn(0, 1, 1, 32'h0, 32'h8000_0040, wd, 2, 0, 0, 0);
    check("t3_write_cycles", 256'(n_wr_cyc), 256'(6));
    check("t3_d1_held", 256'(n_d1_cyc), 256'(3));
    check("t3_latency", 256'(lat), 256'(7));

    // reset in the middle of a read burst, then a clean read
    mix = 32'h0BAD_F00D;
    run_txn(1, 0, 0, 32'h0000_2468, 32'h0, '0, 0, 0, 2, 0);
    mix = 32'h1357_9BDF;
    run_txn(1, 0, 0, 32'h0000_3300, 32'h0, '0, 0, 0, 0, 0);

    // contention twice back-to-back, then the icache alone
    mix = 32'hA5A5_0001;
    run_txn(1, 1, 0, 32'h0000_5000, 32'h0000_6010, '0, 0, 0, 0, 1);
    check("arb_first_dc", 256'(got_dc), 256'(1));
    mix = 32'hA5A5_0002;
    run_txn(1, 1, 0, 32'h0000_5000, 32'h0000_6010, '0, 0, 0, 0, 1);
    check("arb_second_dc", 256'(got_dc), 256'(SECOND_D));
    mix = 32'hA5A5_0003;
    run_txn(1, 0, 0, 32'h0000_5000, 32'h0, '0, 0, 0, 0, 0);

    // stray beats with a foreign tag interleaved with the real ones
    mix = 32'h5EED_0001;
    run_txn(1, 0, 0, 32'h0000_7788, 32'h0, '0, 0, 1, 0, 0);
    check("stray_line", obs_ic, exp_line());

    // random traffic; a contended loser is served next with the same request
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(2);
      ra = $urandom; rb = $urandom; rwe = 1'($urandom_range(1));
      wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      mix = $urandom;
      if (kind == 2) begin
        run_txn(1, 1, rwe, ra, rb, wd, 1, 1, 0, 1);
        lose_d = got_ic;
        mix = $urandom;
        run_txn(!lose_d, lose_d, rwe, ra, rb, wd, 1, 1, 0, 0);
      end else begin
        run_txn(kind == 0, kind == 1, rwe, ra, rb, wd, 1, 1, 0, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
